// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: word geometry, FSM state
// encoding and a helper for sizing the wait-state counter.
package mem_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned BYTE_OFFSET_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter must hold WAIT_CYCLES; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned wait_cycles);
      int unsigned w;
      w = $clog2(wait_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Index width for a word array; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word array with a registered read port.
// Ports:
//   clk    - clock
//   rst_n  - async active-low reset (clears the read register only)
//   en     - perform an access this edge
//   we     - write enable (qualified by en)
//   zero   - load zero into the read register instead of array data
//   idx    - word index
//   wdata  - write data
//   rdata  - registered read data
module word_ram
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IDX_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic              zero,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdata;

   // Array storage; intentionally not reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         r_mem[idx] <= wdata;
      end
   end

   // Read register; zero is used for write acks and illegal accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (en) begin
         r_rdata <= zero ? '0 : r_mem[idx];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for a combined instruction/data port. Accepts one
// word request at a time, inserts WAIT_CYCLES wait states, then presents a
// read-data or write-ack response held until consumed.
// Ports:
//   clock, resetN          - clock, async active-low reset
//   reqValid/reqReady      - request handshake (reqReady registered)
//   reqWrite               - 1 = write, 0 = read
//   reqAddr                - byte address
//   reqWData               - write data
//   respValid/respReady    - response handshake (respValid registered)
//   respRData              - read data, 0 on write ack or error
//   respError              - misaligned or out-of-range access
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [WORD_W-1:0] reqWData,
   output logic              respValid,
   input  logic              respReady,
   output logic [WORD_W-1:0] respRData,
   output logic              respError
);

   localparam int unsigned CNT_W  = cnt_width(WAIT_CYCLES);
   localparam int unsigned IDX_W  = idx_width(DEPTH);
   localparam int unsigned WIDX_W = ADDR_W - BYTE_OFFSET_W;

   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_CYCLES);
   localparam logic [WIDX_W-1:0] DEPTH_IDX = WIDX_W'(DEPTH);

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;

   logic               r_write;
   logic [ADDR_W-1:0]  r_addr;
   logic [WORD_W-1:0]  r_wdata;

   logic               r_req_ready;
   logic               r_resp_valid;
   logic               r_resp_error;

   logic               w_accept;
   logic               w_acc_write;
   logic [ADDR_W-1:0]  w_acc_addr;
   logic [WORD_W-1:0]  w_acc_wdata;
   logic [WIDX_W-1:0]  w_word_idx;
   logic               w_err;
   logic               w_ram_en;
   logic               w_ram_we;
   logic               w_ram_zero;
   logic [WORD_W-1:0]  w_ram_rdata;

   assign w_accept = reqValid & r_req_ready;

   // With zero wait states the access happens on the accept edge, before the
   // request is latched, so the access fields come straight from the port.
   assign w_acc_write = (r_state == IDLE) ? reqWrite : r_write;
   assign w_acc_addr  = (r_state == IDLE) ? reqAddr  : r_addr;
   assign w_acc_wdata = (r_state == IDLE) ? reqWData : r_wdata;

   // Legality of the access about to be performed.
   assign w_word_idx = w_acc_addr[ADDR_W-1:BYTE_OFFSET_W];
   assign w_err      = (|w_acc_addr[BYTE_OFFSET_W-1:0]) | (w_word_idx >= DEPTH_IDX);

   // State and counter registers.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic and array access strobe.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_ram_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES == 0) begin
                  w_next_state = RESP;
                  w_ram_en     = 1'b1;
               end else begin
                  w_next_state = WAIT;
                  w_cnt_next   = CNT_W'(1);
               end
            end
         end
         WAIT: begin
            if (r_cnt == WAIT_LAST) begin
               w_next_state = RESP;
               w_cnt_next   = '0;
               w_ram_en     = 1'b1;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         RESP: begin
            if (respReady) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign w_ram_we   = w_acc_write & ~w_err;
   assign w_ram_zero = w_acc_write | w_err;

   // Request latch.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_write <= reqWrite;
         r_addr  <= reqAddr;
         r_wdata <= reqWData;
      end
   end

   // Handshake and error outputs, registered from the next state.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_error <= 1'b0;
      end else begin
         r_req_ready  <= (w_next_state == IDLE);
         r_resp_valid <= (w_next_state == RESP);
         if (w_ram_en) begin
            r_resp_error <= w_err;
         end
      end
   end

   word_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_word_ram (
      .clk   (clock),
      .rst_n (resetN),
      .en    (w_ram_en),
      .we    (w_ram_we),
      .zero  (w_ram_zero),
      .idx   (w_word_idx[IDX_W-1:0]),
      .wdata (w_acc_wdata),
      .rdata (w_ram_rdata)
   );

   assign reqReady  = r_req_ready;
   assign respValid = r_resp_valid;
   assign respRData = w_ram_rdata;
   assign respError = r_resp_error;

endmodule
